imem_loader: RTL and testbench

//  Boot-time stage directly upstream of the single-cycle MIPS core and its instruction memory.

---
 rtl/loader_pkg.sv | 5 +
 rtl/word_assembler.sv | 28 ++
 rtl/imem_loader.sv | 97 +++++++++
 tb/tb_imem_loader.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared state encoding and framing constants for the imem boot loader
package loader_pkg;
   typedef enum logic [2:0] {LEN_LO, LEN_HI, DATA, CSUM, RUN, ERR} loader_state_t;
   localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/word_assembler.sv
// rtl/word_assembler.sv - packs accepted bytes little-endian into 32-bit words
module word_assembler
   import loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  din,
   input  logic        accept,
   output logic [31:0] word,
   output logic [1:0]  byte_idx,
   output logic        word_done
);
   logic [23:0] partial;

   // word is the completed value on the cycle the final byte is accepted
   assign word      = {din, partial};
   assign word_done = accept && (byte_idx == 2'(BYTES_PER_WORD - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         partial  <= '0;
         byte_idx <= '0;
      end else if (accept) begin
         partial  <= {din, partial[23:8]};
         byte_idx <= byte_idx + 2'd1;
      end
   end
endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - streams a checksummed image into imem and releases the core when verified
module imem_loader
   import loader_pkg::*;
#(
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_wa,
   output logic [31:0]       imem_wd,
   output logic              core_reset,
   output logic              done,
   output logic              error
);
   localparam logic [16:0] CAPACITY = 17'd1 << ADDR_W;

   loader_state_t     state, next_state;
   logic [7:0]        len_lo;
   logic [15:0]       len;
   logic [7:0]        csum;
   logic [ADDR_W:0]   wcount;
   logic              accept;
   logic [15:0]       n_hi;
   logic              last_word;
   logic [31:0]       word;
   logic [1:0]        byte_idx;
   logic              word_done;

   assign accept    = in_valid && in_ready;
   assign n_hi      = {in_data, len_lo};
   // wcount is one bit wider than the address so a full 2**ADDR_W image never wraps
   assign last_word = ({{(15 - ADDR_W){1'b0}}, wcount} == (len - 16'd1));

   word_assembler u_asm (
      .clk       (clk),
      .reset     (reset),
      .din       (in_data),
      .accept    (accept && (state == DATA)),
      .word      (word),
      .byte_idx  (byte_idx),
      .word_done (word_done)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= LEN_LO;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         LEN_LO: if (accept) next_state = LEN_HI;
         LEN_HI: if (accept) begin
            if (n_hi == 16'd0)                next_state = CSUM;
            else if ({1'b0, n_hi} > CAPACITY) next_state = ERR;
            else                              next_state = DATA;
         end
         DATA: if (accept && (byte_idx == 2'd3) && last_word) next_state = CSUM;
         CSUM: if (accept) next_state = (in_data == csum) ? RUN : ERR;
         default: next_state = state;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         len_lo     <= '0;
         len        <= '0;
         csum       <= '0;
         wcount     <= '0;
         in_ready   <= 1'b1;
         imem_we    <= 1'b0;
         imem_wa    <= '0;
         imem_wd    <= '0;
         core_reset <= 1'b1;
         done       <= 1'b0;
         error      <= 1'b0;
      end else begin
         if (accept && (state == LEN_LO)) len_lo <= in_data;
         if (accept && (state == LEN_HI)) len    <= n_hi;
         if (accept && (state inside {LEN_LO, LEN_HI, DATA})) csum <= csum ^ in_data;
         imem_we <= word_done;
         if (word_done) begin
            imem_wa <= wcount[ADDR_W-1:0];
            imem_wd <= word;
            wcount  <= wcount + 1'b1;
         end
         in_ready   <= next_state inside {LEN_LO, LEN_HI, DATA, CSUM};
         core_reset <= (next_state != RUN);
         done       <= (next_state == RUN);
         error      <= (next_state == ERR);
      end
   end
endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - table-driven frames with a write scoreboard for imem_loader
module tb_imem_loader;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        imem_we;
   logic [5:0]  imem_wa;
   logic [31:0] imem_wd;
   logic        core_reset;
   logic        done;
   logic        error;

   int checks = 0;
   int fails  = 0;
   logic [37:0] sb[$];
   logic [7:0]  csum_m;

   typedef struct {
      logic [15:0] len;
      int          nsend;
      bit          send_csum;
      logic [7:0]  cflip;
      int          stall_pct;
      bit          exp_done;
      bit          exp_err;
   } vec_t;

   vec_t vecs[6];

   imem_loader #(.ADDR_W(6)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .imem_we    (imem_we),
      .imem_wa    (imem_wa),
      .imem_wd    (imem_wd),
      .core_reset (core_reset),
      .done       (done),
      .error      (error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && imem_we) begin
         checks++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_write: got addr %0d data %h expected no write", imem_wa, imem_wd);
         end else begin
            logic [37:0] e;
            e = sb.pop_front();
            if ({imem_wa, imem_wd} !== e) begin
               fails++;
               $display("FAIL write: got %0d/%h expected %0d/%h", imem_wa, imem_wd, e[37:32], e[31:0]);
            end
         end
         checks++;
         if (core_reset !== 1'b1) begin
            fails++;
            $display("FAIL write_before_release: got core_reset %b expected 1", core_reset);
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int stall_pct, input bit acc);
      @(negedge clk);
      while ($urandom_range(99) < stall_pct) begin
         in_valid = 1'b0;
         in_data  = 8'($urandom);
         @(negedge clk);
      end
      if (in_ready !== 1'b1) chk("in_ready_while_loading", {63'd0, in_ready}, 64'd1);
      in_data  = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (acc) csum_m = csum_m ^ b;
   endtask

   function automatic logic [31:0] word_of(input int idx);
      if (idx == 0) return 32'h12345678;
      if (idx == 1) return 32'hDEADBEEF;
      return $urandom;
   endfunction

   task automatic send_words(input int n, input int stall_pct);
      for (int w = 0; w < n; w++) begin
         logic [31:0] d;
         d = word_of(w);
         sb.push_back({6'(w), d});
         for (int b = 0; b < 4; b++) send_byte(d[8*b +: 8], stall_pct, 1'b1);
      end
   endtask

   task automatic run_vec(input int i, input vec_t v);
      string tag;
      tag = $sformatf("v%0d", i);
      csum_m = 8'h00;
      send_byte(v.len[7:0], v.stall_pct, 1'b1);
      send_byte(v.len[15:8], v.stall_pct, 1'b1);
      send_words(v.nsend, v.stall_pct);
      if (v.send_csum) begin
         send_byte(csum_m ^ v.cflip, v.stall_pct, 1'b0);
         chk({tag, "_core_reset_edge"}, {63'd0, core_reset}, {63'd0, !v.exp_done});
      end
      repeat (3) @(negedge clk);
      // bytes offered after termination must be ignored
      in_valid = 1'b1;
      in_data  = 8'hA5;
      repeat (3) @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk({tag, "_done"},       {63'd0, done},       {63'd0, v.exp_done});
      chk({tag, "_error"},      {63'd0, error},      {63'd0, v.exp_err});
      chk({tag, "_in_ready"},   {63'd0, in_ready},   64'd0);
      chk({tag, "_core_reset"}, {63'd0, core_reset}, {63'd0, !v.exp_done});
      chk({tag, "_sb_empty"},   64'(sb.size()),      64'd0);
      sb.delete();
   endtask

   initial begin
      vecs[0] = '{16'd2,    2,  1'b1, 8'h00, 0,  1'b1, 1'b0};
      vecs[1] = '{16'd2,    2,  1'b1, 8'h01, 0,  1'b0, 1'b1};
      vecs[2] = '{16'd0,    0,  1'b1, 8'h00, 0,  1'b1, 1'b0};
      vecs[3] = '{16'h0041, 0,  1'b0, 8'h00, 0,  1'b0, 1'b1};
      vecs[4] = '{16'd64,   64, 1'b1, 8'h00, 40, 1'b1, 1'b0};
      vecs[5] = '{16'd3,    3,  1'b1, 8'h00, 30, 1'b1, 1'b0};

      repeat (2) @(negedge clk);
      chk("rst_in_ready",   {63'd0, in_ready},   64'd1);
      chk("rst_imem_we",    {63'd0, imem_we},    64'd0);
      chk("rst_imem_wa",    64'(imem_wa),        64'd0);
      chk("rst_imem_wd",    64'(imem_wd),        64'd0);
      chk("rst_core_reset", {63'd0, core_reset}, 64'd1);
      chk("rst_done",       {63'd0, done},       64'd0);
      chk("rst_error",      {63'd0, error},      64'd0);
      reset = 1'b0;

      for (int i = 0; i < 6; i++) begin
         run_vec(i, vecs[i]);
         do_reset();
      end

      // abort mid-word: reset lands between clock edges
      csum_m = 8'h00;
      send_byte(8'h02, 0, 1'b1);
      send_byte(8'h00, 0, 1'b1);
      send_words(1, 0);
      send_byte(8'h11, 0, 1'b1);
      send_byte(8'h22, 0, 1'b1);
      @(negedge clk);
      chk("abort_sb_empty", 64'(sb.size()), 64'd0);
      #2 reset = 1'b1;
      #1;
      chk("abort_core_reset", {63'd0, core_reset}, 64'd1);
      chk("abort_imem_wd",    64'(imem_wd),        64'd0);
      chk("abort_in_ready",   {63'd0, in_ready},   64'd1);
      chk("abort_done",       {63'd0, done},       64'd0);
      @(negedge clk);
      reset = 1'b0;
      run_vec(6, vecs[0]);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
